// File: rtl/fetch_pkg.sv
// Shared constants, default widths and FSM state type for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned PC_WIDTH_DEF   = 8;
  localparam int unsigned IMEM_DEPTH_DEF = 14;
  localparam int unsigned BUF_DEPTH_DEF  = 2;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } fetch_state_t;

  function automatic logic is_jump(input logic [5:0] opcode);
    return (opcode == OP_J) || (opcode == OP_JAL);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; a head popped in the flush cycle counts as consumed by the reader.
module fetch_fifo #(
  parameter  int unsigned DATA_W = 40,
  parameter  int unsigned DEPTH  = 2,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
  assign do_pop     = pop && head_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Popped head already left with the reader; everything else is dropped, so empty either way.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, RUN/DONE FSM, next-PC mux and fetch FIFO toward decode.
// Optional j/jal predecode enabled by defining FETCH_PREDECODE_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF,
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] prog_counter,
  input  logic [31:0]         instruction,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst_data,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic                fetch_done
);

  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned DATA_W = 32 + PC_WIDTH;

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] next_pc;
  logic                done_q;
  logic [CNT_W-1:0]    count;
  logic                in_range;
  logic                has_room;
  logic                enq;
  logic [DATA_W-1:0]   head_data;

  assign prog_counter = pc;
  assign fetch_done   = done_q;
  assign in_range     = {1'b0, pc} < (PC_WIDTH + 1)'(IMEM_DEPTH);
  assign has_room     = count < CNT_W'(BUF_DEPTH);
  assign enq          = (state == RUN) && has_room && in_range && !redirect_valid;

  always_comb begin
`ifdef FETCH_PREDECODE_EN
    next_pc = is_jump(instruction[31:26]) ? instruction[PC_WIDTH-1:0] : pc + 1'b1;
`else
    next_pc = pc + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      state  <= RUN;
      done_q <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= redirect_target;
      state  <= RUN;
      done_q <= 1'b0;
    end else if (state == RUN) begin
      if (!in_range) begin
        state  <= DONE;
        done_q <= 1'b1;
      end else if (has_room) begin
        pc <= next_pc;
      end
    end
  end

  fetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (enq),
    .push_data  ({instruction, pc}),
    .pop        (inst_ready),
    .flush      (redirect_valid),
    .head_valid (inst_valid),
    .head_data  (head_data),
    .count      (count)
  );

  assign inst_data = head_data[DATA_W-1:PC_WIDTH];
  assign inst_pc   = head_data[PC_WIDTH-1:0];

endmodule
